// File: rtl/rx_block_assembler_pkg.sv
// Shared types and constants for the receive-side block assembler.
package rx_block_assembler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } t_rx_blk_state;

  localparam logic [15:0] c_ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rx_block_buffer_ram.sv
// Simple dual-port block buffer: one write port, one registered read port.
module rx_block_buffer_ram #(
  parameter int g_data_width = 64,
  parameter int g_depth      = 16,
  localparam int AW          = $clog2(g_depth)
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [g_data_width-1:0] wr_data_i,
  input  logic                    rd_en_i,
  input  logic [AW-1:0]           rd_addr_i,
  output logic [g_data_width-1:0] rd_data_o
);

  logic [g_data_width-1:0] mem [g_depth];
  logic [g_data_width-1:0] rd_data_q;

  // Read data holds while rd_en_i is low so a stalled pipeline keeps its word.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rx_block_assembler.sv
// Buffers blocks from rx_streamer and forwards only complete, intact blocks downstream.
// state | meaning:  IDLE no block open | RECV block open, words being stored | DROP discarding rest of a bad block
module rx_block_assembler
  import rx_block_assembler_pkg::*;
#(
  parameter int g_data_width      = 64,
  parameter int g_max_block_words = 8,
  parameter int g_buf_words       = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [g_data_width-1:0]         rx_data_i,
  input  logic                            rx_valid_i,
  input  logic                            rx_first_i,
  input  logic                            rx_last_i,
  input  logic                            rx_lost_i,
  output logic                            rx_dreq_o,
  output logic [g_data_width-1:0]         blk_data_o,
  output logic                            blk_valid_o,
  output logic                            blk_first_o,
  output logic                            blk_last_o,
  input  logic                            blk_ready_i,
  output logic [$clog2(g_buf_words):0]    blk_pending_o,
  output logic                            drop_p1_o,
  output logic [15:0]                     err_cnt_o
);

  localparam int AW = $clog2(g_buf_words);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(g_max_block_words + 1);

  t_rx_blk_state state_q, state_d, eval_state;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [PW-1:0] wbase, used, free;
  logic [LW-1:0] cnt_q, cnt_d, cnt_next, push_len;
  logic [LW-1:0] fidx_q, fidx_d, head_len;
  logic [AW-1:0] lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d;
  logic [LW-1:0] lf_mem [g_buf_words];
  logic [PW-1:0] pending_q, pending_d;
  logic [15:0]   err_q, err_d;
  logic          drop_q, drop_d;
  logic          dreq_q, dreq_d;
  logic          we, commit, abort, at_max;
  logic          lost_open;

  logic                    s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic                    out_v_q, out_v_d, out_first_q, out_first_d, out_last_q, out_last_d;
  logic [g_data_width-1:0] out_data_q, out_data_d, ram_rd_data;
  logic                    adv, issue, accept, f_last;

  // A lost pulse closes any open block before the same-cycle word is looked at.
  assign lost_open  = rx_lost_i && (state_q == RECV);
  assign eval_state = rx_lost_i ? IDLE : state_q;
  assign cnt_next   = cnt_q + LW'(1);
  assign at_max     = (cnt_next == LW'(g_max_block_words));
  assign wbase      = rx_first_i ? commit_ptr_q : wr_ptr_q;
  assign push_len   = rx_first_i ? LW'(1) : cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = eval_state;
    if (rx_valid_i) begin
      if (rx_first_i)              state_d = rx_last_i ? IDLE : RECV;
      else if (eval_state == RECV) state_d = rx_last_i ? IDLE : (at_max ? DROP : RECV);
      else                         state_d = rx_last_i ? IDLE : DROP;
    end
  end

  always_comb begin
    we     = 1'b0;
    commit = 1'b0;
    abort  = rx_lost_i;
    drop_d = lost_open;
    if (rx_valid_i) begin
      if (rx_first_i) begin
        we     = 1'b1;
        commit = rx_last_i;
        if (eval_state == RECV) drop_d = 1'b1;
      end else if (eval_state == RECV) begin
        if (rx_last_i) begin
          we     = 1'b1;
          commit = 1'b1;
        end else if (at_max) begin
          drop_d = 1'b1;
          abort  = 1'b1;
        end else begin
          we = 1'b1;
        end
      end else if (eval_state == IDLE) begin
        drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d     = abort ? commit_ptr_q : wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cnt_d        = cnt_q;
    lf_wr_d      = lf_wr_q;
    if (we) begin
      wr_ptr_d = wbase + PW'(1);
      cnt_d    = push_len;
    end
    if (commit) begin
      commit_ptr_d = wbase + PW'(1);
      lf_wr_d      = lf_wr_q + AW'(1);
    end
    err_d = (drop_d && err_q != c_ERR_CNT_MAX) ? err_q + 16'd1 : err_q;
  end

  // Space is judged against the read pointer, so words still in the output pipe stay reserved.
  assign used   = wr_ptr_q - rd_ptr_q;
  assign free   = PW'(g_buf_words) - used;
  assign dreq_d = (state_q == RECV) || (free >= PW'(g_max_block_words));

  assign adv      = !out_v_q || blk_ready_i;
  assign accept   = out_v_q && blk_ready_i;
  assign issue    = (fetch_ptr_q != commit_ptr_q) && (adv || !s1_v_q);
  assign head_len = lf_mem[lf_rd_q];
  assign f_last   = (fidx_q == head_len - LW'(1));

  always_comb begin
    fetch_ptr_d = fetch_ptr_q;
    fidx_d      = fidx_q;
    lf_rd_d     = lf_rd_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_v_d      = s1_v_q && !adv;
    if (issue) begin
      fetch_ptr_d = fetch_ptr_q + PW'(1);
      fidx_d      = f_last ? '0 : fidx_q + LW'(1);
      lf_rd_d     = f_last ? lf_rd_q + AW'(1) : lf_rd_q;
      s1_first_d  = (fidx_q == '0);
      s1_last_d   = f_last;
      s1_v_d      = 1'b1;
    end
  end

  always_comb begin
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    if (adv) begin
      out_v_d = s1_v_q;
      if (s1_v_q) begin
        out_data_d  = ram_rd_data;
        out_first_d = s1_first_q;
        out_last_d  = s1_last_q;
      end
    end
    rd_ptr_d  = accept ? rd_ptr_q + PW'(1) : rd_ptr_q;
    pending_d = pending_q + PW'(commit) - PW'(accept && out_last_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      cnt_q        <= '0;
      fidx_q       <= '0;
      lf_wr_q      <= '0;
      lf_rd_q      <= '0;
      pending_q    <= '0;
      err_q        <= '0;
      drop_q       <= 1'b0;
      dreq_q       <= 1'b0;
      s1_v_q       <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      out_v_q      <= 1'b0;
      out_data_q   <= '0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      cnt_q        <= cnt_d;
      fidx_q       <= fidx_d;
      lf_wr_q      <= lf_wr_d;
      lf_rd_q      <= lf_rd_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
      dreq_q       <= dreq_d;
      s1_v_q       <= s1_v_d;
      s1_first_q   <= s1_first_d;
      s1_last_q    <= s1_last_d;
      out_v_q      <= out_v_d;
      out_data_q   <= out_data_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) lf_mem[lf_wr_q] <= push_len;
  end

  rx_block_buffer_ram #(
    .g_data_width (g_data_width),
    .g_depth      (g_buf_words)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (we),
    .wr_addr_i (wbase[AW-1:0]),
    .wr_data_i (rx_data_i),
    .rd_en_i   (issue),
    .rd_addr_i (fetch_ptr_q[AW-1:0]),
    .rd_data_o (ram_rd_data)
  );

  // Upstream honours rx_dreq_o per block, so a write into a full buffer means a broken sender.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    we |-> ((wbase - rd_ptr_q) != PW'(g_buf_words)));

  assign rx_dreq_o     = dreq_q;
  assign blk_data_o    = out_data_q;
  assign blk_valid_o   = out_v_q;
  assign blk_first_o   = out_first_q;
  assign blk_last_o    = out_last_q;
  assign blk_pending_o = pending_q;
  assign drop_p1_o     = drop_q;
  assign err_cnt_o     = err_q;

endmodule

// File: tb/tb_rx_block_assembler.sv
// Randomised and directed bench for rx_block_assembler against a block-level reference model.
module tb_rx_block_assembler;

  localparam int DW = 64, MAXW = 8, BUFW = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] rx_data_i = '0;
  logic          rx_valid_i = 0, rx_first_i = 0, rx_last_i = 0, rx_lost_i = 0;
  logic          rx_dreq_o;
  logic [DW-1:0] blk_data_o;
  logic          blk_valid_o, blk_first_o, blk_last_o;
  logic          blk_ready_i = 0;
  logic [$clog2(BUFW):0] blk_pending_o;
  logic          drop_p1_o;
  logic [15:0]   err_cnt_o;

  rx_block_assembler #(.g_data_width(DW), .g_max_block_words(MAXW), .g_buf_words(BUFW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_first_i(rx_first_i), .rx_last_i(rx_last_i), .rx_lost_i(rx_lost_i),
    .rx_dreq_o(rx_dreq_o), .blk_data_o(blk_data_o), .blk_valid_o(blk_valid_o),
    .blk_first_o(blk_first_o), .blk_last_o(blk_last_o), .blk_ready_i(blk_ready_i),
    .blk_pending_o(blk_pending_o), .drop_p1_o(drop_p1_o), .err_cnt_o(err_cnt_o));

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic f; logic l; } word_t;

  int checks = 0, errors = 0;
  word_t exp_q[$];
  word_t cap_q[$];
  logic [DW-1:0] cur_q[$];
  bit m_open = 0, m_frag = 0, m_drop_now = 0;
  int m_err = 0, m_commits = 0, m_lasts = 0, drop_pulses = 0;
  int rdy_mode = 1;
  bit prev_stall = 0;
  word_t prev_w;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void commit_blk();
    for (int i = 0; i < cur_q.size(); i++)
      exp_q.push_back('{d: cur_q[i], f: (i == 0), l: (i == cur_q.size() - 1)});
    m_commits++;
    m_open = 0;
    cur_q.delete();
  endfunction

  // Block-level reference: tracks the open block as a queue of words.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); cur_q.delete();
      m_open = 0; m_frag = 0; m_drop_now = 0; m_err = 0; m_commits = 0;
    end else begin
      m_drop_now = 0;
      if (rx_lost_i) begin
        if (m_open) m_drop_now = 1;
        m_open = 0; m_frag = 0; cur_q.delete();
      end
      if (rx_valid_i) begin
        if (rx_first_i) begin
          if (m_open) m_drop_now = 1;
          m_frag = 0; cur_q.delete();
          cur_q.push_back(rx_data_i);
          m_open = 1;
          if (rx_last_i) commit_blk();
        end else if (m_open) begin
          cur_q.push_back(rx_data_i);
          if (rx_last_i) commit_blk();
          else if (cur_q.size() >= MAXW) begin
            m_drop_now = 1; m_open = 0; m_frag = 1; cur_q.delete();
          end
        end else if (m_frag) begin
          if (rx_last_i) m_frag = 0;
        end else begin
          m_drop_now = 1;
          m_frag = !rx_last_i;
        end
      end
      if (m_drop_now && m_err < 65535) m_err++;
    end
  end

  always @(negedge clk) begin
    word_t w;
    if (!rst_n) begin
      m_lasts = 0; prev_stall = 0; cap_q.delete();
    end else begin
      chk("pending", 64'(blk_pending_o), 64'(m_commits - m_lasts));
      chk("err_cnt", 64'(err_cnt_o), 64'(m_err));
      chk("drop_p1", 64'(drop_p1_o), 64'(m_drop_now));
      if (drop_p1_o) drop_pulses++;
      if (prev_stall) begin
        chk("hold_data", blk_data_o, prev_w.d);
        chk("hold_vfl", {61'd0, blk_valid_o, blk_first_o, blk_last_o}, {61'd0, 1'b1, prev_w.f, prev_w.l});
      end
      if (blk_valid_o && blk_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got %0h expected no word", blk_data_o);
        end else begin
          w = exp_q.pop_front();
          chk("out_data", blk_data_o, w.d);
          chk("out_fl", {62'd0, blk_first_o, blk_last_o}, {62'd0, w.f, w.l});
        end
        cap_q.push_back('{d: blk_data_o, f: blk_first_o, l: blk_last_o});
        if (blk_last_o) m_lasts++;
      end
      prev_stall = blk_valid_o && !blk_ready_i;
      prev_w = '{d: blk_data_o, f: blk_first_o, l: blk_last_o};
    end
  end

  function automatic logic [63:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  task automatic cyc(input bit v, input bit f, input bit l, input bit lost, input logic [63:0] d);
    rx_valid_i = v; rx_first_i = f; rx_last_i = l; rx_lost_i = lost; rx_data_i = d;
    if (rdy_mode == 0)      blk_ready_i = 0;
    else if (rdy_mode == 1) blk_ready_i = 1;
    else                    blk_ready_i = ($urandom_range(0, 99) < 70);
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, '0);
  endtask

  task automatic wait_dreq();
    int k = 0;
    while (!rx_dreq_o && k < 300) begin idle(1); k++; end
    if (!rx_dreq_o) begin
      checks++; errors++;
      $display("FAIL dreq_timeout: got 0 expected 1 within 300 cycles");
    end
  endtask

  task automatic send_block(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) cyc(1, i == 0, i == n - 1, 0, base + 64'(i));
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      cyc(1, i == 0, i == n - 1, 0, rnd());
    end
  endtask

  task automatic chk_cap(input string nm, input logic [63:0] exp[$]);
    chk({nm, "_len"}, 64'(cap_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap_q.size(); i++) chk(nm, cap_q[i].d, exp[i]);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_valid"}, 64'(blk_valid_o), 0);
    chk({nm, "_fl"}, {62'd0, blk_first_o, blk_last_o}, 0);
    chk({nm, "_data"}, blk_data_o, 0);
    chk({nm, "_pending"}, 64'(blk_pending_o), 0);
    chk({nm, "_drop"}, 64'(drop_p1_o), 0);
    chk({nm, "_err"}, 64'(err_cnt_o), 0);
    chk({nm, "_dreq"}, 64'(rx_dreq_o), 0);
  endtask

  initial begin
    logic [63:0] eq[$];
    bit t1_f[6] = '{1, 1, 0, 1, 0, 0};
    bit t1_l[6] = '{1, 0, 1, 0, 0, 1};
    int dp0, kind, n, k;

    @(posedge clk); #2;
    idle(2);
    chk_reset("rst");
    rst_n = 1;
    idle(1);
    chk("dreq_after_rst", 64'(rx_dreq_o), 1);

    // 1: three short blocks back to back
    rdy_mode = 1; cap_q.delete();
    send_block(1, 0); send_block(2, 1); send_block(3, 3);
    idle(8);
    eq = '{0, 1, 2, 3, 4, 5};
    chk_cap("t1", eq);
    for (int i = 0; i < 6 && i < cap_q.size(); i++)
      chk("t1_fl", {62'd0, cap_q[i].f, cap_q[i].l}, {62'd0, t1_f[i], t1_l[i]});
    chk("t1_err", 64'(err_cnt_o), 0);

    // 2: fill the buffer with the consumer stalled
    rdy_mode = 0; cap_q.delete();
    wait_dreq();
    send_block(8, 64'h100); idle(2);
    chk("t2_dreq_half", 64'(rx_dreq_o), 1);
    send_block(8, 64'h200); idle(2);
    chk("t2_dreq_full", 64'(rx_dreq_o), 0);
    chk("t2_pending", 64'(blk_pending_o), 2);
    rdy_mode = 1; idle(24);
    chk("t2_len", 64'(cap_q.size()), 16);
    for (int i = 0; i < 16 && i < cap_q.size(); i++)
      chk("t2_data", cap_q[i].d, (i < 8) ? 64'h100 + 64'(i) : 64'h200 + 64'(i - 8));
    chk("t2_dreq_drained", 64'(rx_dreq_o), 1);

    // 3: lost pulse abandons an open block
    cap_q.delete(); dp0 = drop_pulses;
    cyc(1, 1, 0, 0, 64'hA); cyc(1, 0, 0, 0, 64'hB); cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 64'hC); cyc(1, 0, 1, 0, 64'hD); idle(6);
    eq = '{64'hC, 64'hD};
    chk_cap("t3", eq);
    chk("t3_pulses", 64'(drop_pulses - dp0), 1);
    chk("t3_err", 64'(err_cnt_o), 1);

    // 4: oversized block then a good one
    cap_q.delete(); dp0 = drop_pulses;
    send_block(9, 64'h300); idle(1); wait_dreq();
    send_block(2, 64'h400); idle(6);
    eq = '{64'h400, 64'h401};
    chk_cap("t4", eq);
    chk("t4_pulses", 64'(drop_pulses - dp0), 1);
    chk("t4_err", 64'(err_cnt_o), 2);

    // 5: restart by a new first, and lost together with first
    cap_q.delete();
    cyc(1, 1, 0, 0, 64'h50); cyc(1, 0, 0, 0, 64'h51);
    cyc(1, 1, 0, 0, 64'h52); cyc(1, 0, 1, 0, 64'h53);
    idle(1); wait_dreq();
    cyc(1, 1, 0, 0, 64'h60); cyc(1, 1, 0, 1, 64'h61); cyc(1, 0, 1, 0, 64'h62);
    idle(6);
    eq = '{64'h52, 64'h53, 64'h61, 64'h62};
    chk_cap("t5", eq);
    chk("t5_err", 64'(err_cnt_o), 4);

    // random traffic
    rdy_mode = 2;
    for (int b = 0; b < 300; b++) begin
      kind = $urandom_range(0, 9);
      idle($urandom_range(1, 3));
      wait_dreq();
      if (kind <= 4) send_rand($urandom_range(1, 8));
      else if (kind == 5) send_rand($urandom_range(9, 12));
      else if (kind == 6) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) cyc(1, 0, i == n - 1, 0, rnd());
      end else if (kind == 7) begin
        k = $urandom_range(0, 6);
        cyc(1, 1, 0, 0, rnd());
        repeat (k) cyc(1, 0, 0, 0, rnd());
        cyc(0, 0, 0, 1, 0);
      end else if (kind == 8) begin
        k = $urandom_range(0, 5);
        cyc(1, 1, 0, 0, rnd());
        repeat (k) cyc(1, 0, 0, 0, rnd());
        send_rand($urandom_range(1, 8));
      end else begin
        k = $urandom_range(0, 5);
        n = $urandom_range(1, 6);
        cyc(1, 1, 0, 0, rnd());
        repeat (k) cyc(1, 0, 0, 0, rnd());
        cyc(1, 1, n == 1, 1, rnd());
        for (int i = 1; i < n; i++) cyc(1, 0, i == n - 1, 0, rnd());
      end
    end
    rdy_mode = 1; idle(40);
    chk("drain_empty", 64'(exp_q.size()), 0);

    // 6: reset with one block pending and another open
    rdy_mode = 0;
    wait_dreq();
    send_block(1, 64'h700);
    cyc(1, 1, 0, 0, 64'h701); cyc(1, 0, 0, 0, 64'h702);
    idle(2);
    chk("t6_pending_before", 64'(blk_pending_o), 1);
    rst_n = 0;
    idle(2);
    chk_reset("t6");
    rst_n = 1; rdy_mode = 1;
    idle(1);
    chk("t6_dreq_after", 64'(rx_dreq_o), 1);
    idle(10);
    chk("t6_no_stale", 64'(cap_q.size()), 0);
    chk("t6_valid", 64'(blk_valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
